ram_sdp: RTL and testbench
==========================

# ram_sdp

Single-clock simple dual-port RAM: one write port and one read port, operating in the same clock domain. `D_WIDTH` bits wide and `A_MAX` words deep. Reads are synchronous with a registered output. It serves as generic on-chip buffer storage (FIFOs, lookup tables, scratch memories) wherever one writer and one reader share a clock.

## Interface
Parameters, positional order `D_WIDTH`, `A_WIDTH`, `A_MAX`:
- `D_WIDTH`, default 8: word width in bits.
- `A_WIDTH`, default 5: address width in bits.
- `A_MAX`, default 32: number of words. Must satisfy 1 ≤ `A_MAX` ≤ 2^`A_WIDTH`.

Ports:
- `clk`, input, 1: single clock. Both ports act on the rising edge. There is one clock; reset is synchronous and active-high.
- `reset`, input, 1: synchronous, active-high reset.
- `address_write`, input, `A_WIDTH`: write address.
- `data_write`, input, `D_WIDTH`: write data.
- `write_enable`, input, 1: write strobe, active-high.
- `address_read`, input, `A_WIDTH`: read address. A read is performed on every cycle.
- `data_read`, output, `D_WIDTH`: registered read data.

## Operation
- **Storage:** array of `A_MAX` words of `D_WIDTH` bits.
  - Contents are initialised to all-zero at power-up/configuration.
  - Contents are not cleared by `reset`.
- **Write:** on a rising edge with `write_enable`=1 and `reset`=0, `mem[address_write]` ← `data_write`.
  - A write with `address_write` ≥ `A_MAX` is ignored; no aliasing and no wrap.
- **Read:** on every rising edge with `reset`=0, `data_read` ← `mem[address_read]`.
  - If `address_read` ≥ `A_MAX`, `data_read` ← 0.
- **Reset:** on a rising edge with `reset`=1:
  - `data_read` ← 0.
  - Any write presented in that cycle is suppressed.
  - Memory contents are otherwise retained.
- **Read-during-write, same address, same edge:** read-first. `data_read` returns the old contents; the new value is visible from the next read.
- **Read-during-write, different addresses:** fully independent, no interaction.
- No handshake and no back-pressure. Both ports accept a new operation every cycle.
- All state changes are on the `clk` rising edge only. There are no combinational paths from inputs to `data_read`.

## Timing
- **Write latency:** data written at edge N is readable by a read sampled at edge N+1 and appears on `data_read` after edge N+1.
- **Read latency:** 1 cycle. The address applied before edge N produces data on `data_read` after edge N, held until the next edge.
- **Throughput:** one read and one write per cycle.
- **Reset value:** `data_read` = 0 from the first edge with `reset`=1, until the first read edge after `reset` deasserts.
- **Reset asserted mid-stream:** the read register clears on that edge, pending writes in that cycle are dropped, and stored words are unaffected.
- **Back-to-back writes to the same address:** the last write wins.

## Test plan
- **Initial read:** after power-up with no writes, set `address_read`=5'h1B and clock once → `data_read`=8'h00.
- **Write then read:** `write_enable`=1, `address_write`=5'h1B, `data_write`=8'hC5, one edge; then `write_enable`=0, `address_read`=5'h1B, one edge → `data_read`=8'hC5. Address 5'h1A still reads 8'h00.
- **Read-first collision:** mem[3]=8'h11. In the same cycle write 8'h22 to address 3 and read address 3 → `data_read`=8'h11 after that edge and 8'h22 after the following edge.
- **Reset:** mem[5]=8'hAB and `data_read`=8'hAB. Assert `reset` for one edge while writing 8'hFF to address 5 → `data_read`=8'h00. Deassert and read address 5 → 8'hAB (write suppressed, contents retained).
- **Out-of-range (`A_MAX`=20):** write 8'h5A to address 25 → ignored. Reading address 25 gives 8'h00, and reading address 5 is unchanged (no aliasing).
- **Full sweep:** write `addr`^8'hA5 to all 32 addresses in 32 consecutive cycles, then read all 32 back-to-back → each `data_read` matches one cycle after its address is applied.

Source files
------------

// File: rtl/ram_sdp.sv
// ram_sdp: single-clock simple dual-port RAM, read-first, registered read, out-of-range accesses ignored
module ram_sdp #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [A_WIDTH-1:0] address_write,
    input  logic [D_WIDTH-1:0] data_write,
    input  logic               write_enable,
    input  logic [A_WIDTH-1:0] address_read,
    output logic [D_WIDTH-1:0] data_read
);
    logic [D_WIDTH-1:0] mem [A_MAX] = '{default: '0};
    logic               write_ok;
    logic               read_ok;
    always_comb begin
        write_ok = write_enable && !reset && (int'(address_write) < A_MAX);
        read_ok  = int'(address_read) < A_MAX;
    end
    always_ff @(posedge clk) begin
        if (write_ok) mem[address_write] <= data_write;
    end
    always_ff @(posedge clk) begin
        if (reset) data_read <= '0;
        else data_read <= read_ok ? mem[address_read] : '0;
    end
endmodule

// File: tb/tb_ram_sdp.sv
// tb_ram_sdp: directed checks of ram_sdp at full depth (32) and reduced depth (20)
module tb_ram_sdp;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] address_write;
    logic [7:0] data_write;
    logic       write_enable;
    logic [4:0] address_read;
    logic [7:0] data_read_a;
    logic [7:0] data_read_b;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    ram_sdp #(.D_WIDTH(8), .A_WIDTH(5), .A_MAX(32)) u_a (
        .clk(clk), .reset(reset), .address_write(address_write), .data_write(data_write),
        .write_enable(write_enable), .address_read(address_read), .data_read(data_read_a)
    );

    ram_sdp #(.D_WIDTH(8), .A_WIDTH(5), .A_MAX(20)) u_b (
        .clk(clk), .reset(reset), .address_write(address_write), .data_write(data_write),
        .write_enable(write_enable), .address_read(address_read), .data_read(data_read_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        write_enable  = 1'b1;
        address_write = a;
        data_write    = d;
        tick();
        write_enable  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        address_read = a;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        address_write = '0;
        data_write = '0;
        write_enable = 1'b0;
        address_read = '0;
        tick();
        chk("reset_a", data_read_a, 8'h00);
        chk("reset_b", data_read_b, 8'h00);
        reset = 1'b0;
        rd(5'h1B);
        chk("initial_read", data_read_a, 8'h00);
        wr(5'h1B, 8'hC5);
        rd(5'h1B);
        chk("write_read", data_read_a, 8'hC5);
        rd(5'h1A);
        chk("neighbour", data_read_a, 8'h00);
        wr(5'd3, 8'h11);
        write_enable = 1'b1;
        address_write = 5'd3;
        data_write = 8'h22;
        address_read = 5'd3;
        tick();
        write_enable = 1'b0;
        chk("collision_old", data_read_a, 8'h11);
        tick();
        chk("collision_new", data_read_a, 8'h22);
        wr(5'd5, 8'hAB);
        rd(5'd5);
        chk("pre_reset", data_read_a, 8'hAB);
        reset = 1'b1;
        write_enable = 1'b1;
        address_write = 5'd5;
        data_write = 8'hFF;
        tick();
        reset = 1'b0;
        write_enable = 1'b0;
        chk("reset_clears", data_read_a, 8'h00);
        tick();
        chk("reset_retains", data_read_a, 8'hAB);
        wr(5'd25, 8'h5A);
        rd(5'd25);
        chk("oor_read_b", data_read_b, 8'h00);
        chk("inrange_25_a", data_read_a, 8'h5A);
        rd(5'd5);
        chk("oor_no_alias5", data_read_b, 8'hAB);
        rd(5'd9);
        chk("oor_no_alias9", data_read_b, 8'h00);
        wr(5'd7, 8'h01);
        wr(5'd7, 8'h02);
        rd(5'd7);
        chk("last_write_wins", data_read_a, 8'h02);
        for (int i = 0; i < 32; i++) begin
            write_enable = 1'b1;
            address_write = 5'(i);
            data_write = 8'(i) ^ 8'hA5;
            tick();
        end
        write_enable = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd(5'(i));
            chk($sformatf("sweep_a[%0d]", i), data_read_a, 8'(i) ^ 8'hA5);
            chk($sformatf("sweep_b[%0d]", i), data_read_b, (i < 20) ? (8'(i) ^ 8'hA5) : 8'h00);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
